// File: rtl/bpm_step_sequencer_pkg.sv
// Shared transport definitions for the step sequencer and the drum datapath.
// Holds the state encodings, step count and the tempo clamp helper.
package bpm_step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } tstate_e;

    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = $clog2(NUM_STEPS);

    typedef struct packed {
        logic start;
        logic stop;
        logic pause;
    } xport_cmd_t;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] bpm, input int lo, input int hi);
        if (int'(bpm) < lo)      return 8'(lo);
        else if (int'(bpm) > hi) return 8'(hi);
        else                     return bpm;
    endfunction

endpackage

// File: rtl/bpm_step_sequencer_phase_acc.sv
// Phase accumulator: adds the clamped tempo each running cycle and strobes on
// every crossing of THRESH, carrying the remainder so the average rate is exact.
module bpm_step_sequencer_phase_acc
    import bpm_step_sequencer_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS_PER_BEAT = 2,
    parameter int MIN_BPM        = 40,
    parameter int MAX_BPM        = 240,
    parameter int ACC_W          = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] set_bpm,
    input  logic       run,
    input  logic       clear,
    output logic       ovf
);

    // Computed in 64 bits: CLK_HZ*60 exceeds a 32-bit int at real clock rates.
    localparam longint          THRESH_L = longint'(CLK_HZ) * 60 / STEPS_PER_BEAT;
    localparam logic [ACC_W-1:0] THRESH  = ACC_W'(THRESH_L);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [7:0]       bpm_c;
    logic             hit;

    always_comb begin
        bpm_c = clamp_bpm(set_bpm, MIN_BPM, MAX_BPM);
        sum   = acc + ACC_W'(bpm_c);
        hit   = (sum >= THRESH);
        ovf   = run && hit;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear)
            acc <= '0;
        else if (run)
            acc <= hit ? (sum - THRESH) : sum;
    end

endmodule

// File: rtl/bpm_step_sequencer.sv
// Transport FSM and step counter; every output is registered so timing and
// step_tick change on the same edge as seen by the datapath.
module bpm_step_sequencer
    import bpm_step_sequencer_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS_PER_BEAT = 2,
    parameter int MIN_BPM        = 40,
    parameter int MAX_BPM        = 240,
    parameter int ACC_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        set_bpm,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic              play,
    output logic [STEP_W-1:0] timing,
    output logic              step_tick,
    output logic              bar_start,
    output logic              beat_led
);

    tstate_e           state, state_nxt;
    xport_cmd_t        cmd;
    logic              ovf, run, clear, start_edge;
    logic [STEP_W-1:0] timing_nxt;
    logic              tick_nxt, bar_nxt, play_nxt, beat_nxt;

    assign cmd = '{start: start, stop: stop, pause: pause};

    bpm_step_sequencer_phase_acc #(
        .CLK_HZ        (CLK_HZ),
        .STEPS_PER_BEAT(STEPS_PER_BEAT),
        .MIN_BPM       (MIN_BPM),
        .MAX_BPM       (MAX_BPM),
        .ACC_W         (ACC_W)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .set_bpm(set_bpm),
        .run    (run),
        .clear  (clear),
        .ovf    (ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_STOPPED;
        else        state <= state_nxt;
    end

    // stop > pause > start; pause only means something while playing.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOPPED: if (!cmd.stop && cmd.start) state_nxt = ST_PLAYING;
            ST_PLAYING: if (cmd.stop)               state_nxt = ST_STOPPED;
                        else if (cmd.pause)         state_nxt = ST_PAUSED;
            ST_PAUSED:  if (cmd.stop)               state_nxt = ST_STOPPED;
                        else if (cmd.start)         state_nxt = ST_PLAYING;
            default:                                state_nxt = ST_STOPPED;
        endcase
    end

    // Accumulate only on edges that stay in PLAYING, so a pause edge never ticks
    // and a resume edge does not double-count the frozen phase.
    always_comb begin
        start_edge = (state == ST_STOPPED) && (state_nxt == ST_PLAYING);
        run        = (state == ST_PLAYING) && (state_nxt == ST_PLAYING);
        clear      = (state_nxt == ST_STOPPED);
        timing_nxt = timing;
        if (clear || start_edge) timing_nxt = '0;
        else if (ovf)            timing_nxt = timing + 1'b1;
        play_nxt = (state_nxt == ST_PLAYING);
        tick_nxt = start_edge || ovf;
        bar_nxt  = start_edge || (ovf && timing_nxt == '0);
        beat_nxt = play_nxt && ((int'(timing_nxt) % STEPS_PER_BEAT) == 0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timing    <= '0;
            play      <= 1'b0;
            step_tick <= 1'b0;
            bar_start <= 1'b0;
            beat_led  <= 1'b0;
        end else begin
            timing    <= timing_nxt;
            play      <= play_nxt;
            step_tick <= tick_nxt;
            bar_start <= bar_nxt;
            beat_led  <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_bpm_step_sequencer.sv
// Directed bench for bpm_step_sequencer at CLK_HZ=60, 2 steps/beat (THRESH=1800).
// Expected ticks are queued as stimulus is applied and checked as they arrive.
module tb_bpm_step_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] set_bpm = 8'd0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       play, step_tick, bar_start, beat_led;
    logic [2:0] timing;

    bpm_step_sequencer #(
        .CLK_HZ(60), .STEPS_PER_BEAT(2), .MIN_BPM(40), .MAX_BPM(240), .ACC_W(32)
    ) dut (
        .clk(clk), .reset(reset), .set_bpm(set_bpm),
        .start(start), .stop(stop), .pause(pause),
        .play(play), .timing(timing), .step_tick(step_tick),
        .bar_start(bar_start), .beat_led(beat_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         gap;
        logic [2:0] tim;
        logic       bar;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, last_tick = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int gap, input logic [2:0] tim, input logic bar);
        exp_t e;
        e.tag = tag; e.gap = gap; e.tim = tim; e.bar = bar;
        sbq.push_back(e);
    endtask

    // One full bar at the given gap, starting from timing 0: steps 1..7 then 0.
    task automatic push_bar(input string tag, input int gap);
        for (int i = 1; i <= 8; i++)
            push(tag, gap, 3'(i % 8), (i == 8));
    endtask

    task automatic drain(input int budget);
        int   spent = 0, spur = 0;
        exp_t e;
        while (sbq.size() > 0 && spent < budget) begin
            step();
            spent++;
            if (step_tick) begin
                e = sbq.pop_front();
                chk({e.tag, "_gap"},    cyc - last_tick, e.gap);
                chk({e.tag, "_timing"}, timing, e.tim);
                chk({e.tag, "_bar"},    bar_start, e.bar);
                chk({e.tag, "_beat"},   beat_led, (e.tim % 2 == 0));
                chk({e.tag, "_play"},   play, 1);
                last_tick = cyc;
            end else if (bar_start || !play) begin
                spur++;
            end
        end
        chk("drain_timeout", sbq.size(), 0);
        sbq.delete();
        chk("drain_spurious", spur, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic check_start_edge(input string tag);
        chk({tag, "_tick"},   step_tick, 1);
        chk({tag, "_bar"},    bar_start, 1);
        chk({tag, "_timing"}, timing, 0);
        chk({tag, "_play"},   play, 1);
        chk({tag, "_beat"},   beat_led, 1);
        last_tick = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_play"},   play, 0);
        chk({tag, "_timing"}, timing, 0);
        chk({tag, "_tick"},   step_tick, 0);
        chk({tag, "_bar"},    bar_start, 0);
        chk({tag, "_beat"},   beat_led, 0);
    endtask

    initial begin
        int t0, bad_tick, bad_tim, bad_play;

        // 1. reset, start at 120 bpm: tick every 15 cycles, bar on the wrap
        step(); step();
        check_all_zero("reset");
        reset = 1'b1; set_bpm = 8'd120;
        step();
        check_all_zero("idle");
        pulse_start();
        check_start_edge("start1");
        push_bar("bpm120", 15);
        t0 = cyc;
        drain(200);
        chk("bar_period", cyc - t0, 120);

        // 2. clamping: 0 -> 40 (45 cycles), 255 -> 240 (8,7 alternating)
        set_bpm = 8'd0;
        push("bpm40", 45, 3'd1, 1'b0);
        push("bpm40", 45, 3'd2, 1'b0);
        drain(120);
        set_bpm = 8'd255;
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            push("bpm240", (i % 2 == 0) ? 8 : 7, 3'((3 + i) % 8), ((3 + i) % 8) == 0);
        drain(100);
        chk("bpm240_8ticks", cyc - t0, 60);

        // 3. pause at timing 3, acc 600; resume ticks after 10 cycles
        set_bpm = 8'd120;
        push("pre_pause", 15, 3'd3, 1'b0);
        drain(40);
        repeat (5) step();
        pause = 1'b1; step(); pause = 1'b0;
        chk("pause_play", play, 0);
        chk("pause_timing", timing, 3);
        bad_tick = 0; bad_tim = 0; bad_play = 0;
        repeat (100) begin
            step();
            if (step_tick || bar_start) bad_tick++;
            if (timing !== 3'd3) bad_tim++;
            if (play !== 1'b0 || beat_led !== 1'b0) bad_play++;
        end
        chk("hold_ticks", bad_tick, 0);
        chk("hold_timing", bad_tim, 0);
        chk("hold_play", bad_play, 0);
        pulse_start();
        chk("resume_play", play, 1);
        chk("resume_tick", step_tick, 0);
        chk("resume_timing", timing, 3);
        last_tick = cyc;
        push("resume", 10, 3'd4, 1'b0);
        drain(30);

        // 4. pause+start -> PAUSED; stop+start from PAUSED -> STOPPED
        pause = 1'b1; start = 1'b1; step(); pause = 1'b0; start = 1'b0;
        chk("pause_wins_play", play, 0);
        chk("pause_wins_tick", step_tick, 0);
        chk("pause_wins_timing", timing, 4);
        repeat (20) step();
        chk("paused_timing", timing, 4);
        stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
        check_all_zero("stop_wins");
        repeat (20) step();
        check_all_zero("stopped_hold");
        pulse_start();
        check_start_edge("start2");

        // 5. 120 -> 60 at acc=1200: next tick 10 cycles later, then every 30
        repeat (10) step();
        set_bpm = 8'd60;
        last_tick = cyc;
        push("bpm60_first", 10, 3'd1, 1'b0);
        push("bpm60", 30, 3'd2, 1'b0);
        push("bpm60", 30, 3'd3, 1'b0);
        drain(100);

        // 6. reset mid-step at timing 5, then a clean restart
        set_bpm = 8'd120;
        push("pre_reset", 15, 3'd4, 1'b0);
        push("pre_reset", 15, 3'd5, 1'b0);
        drain(50);
        repeat (3) step();
        reset = 1'b0; step(); reset = 1'b1;
        check_all_zero("midreset");
        repeat (20) step();
        check_all_zero("post_reset_idle");
        pulse_start();
        check_start_edge("start3");
        push_bar("restart", 15);
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
